// File: rtl/sram_amm_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM SRAM controller
// port. Outstanding reads are tagged with the issuing master's ID in a small
// FIFO so that each readdatavalid beat is steered back to its owner.
module sram_amm_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 16,
   parameter int MAX_PENDING = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] m0_address_i,
   input  logic              m0_read_i,
   input  logic              m0_write_i,
   input  logic [DATA_W-1:0] m0_writedata_i,
   output logic              m0_waitrequest_o,
   output logic              m0_readdatavalid_o,
   output logic [DATA_W-1:0] m0_readdata_o,
   input  logic [ADDR_W-1:0] m1_address_i,
   input  logic              m1_read_i,
   input  logic              m1_write_i,
   input  logic [DATA_W-1:0] m1_writedata_i,
   output logic              m1_waitrequest_o,
   output logic              m1_readdatavalid_o,
   output logic [DATA_W-1:0] m1_readdata_o,
   output logic [ADDR_W-1:0] s_address_o,
   output logic              s_read_o,
   output logic              s_write_o,
   output logic [DATA_W-1:0] s_writedata_o,
   input  logic              s_waitrequest_i,
   input  logic              s_readdatavalid_i,
   input  logic [DATA_W-1:0] s_readdata_i,
   output logic              err_o
);

   localparam int PTR_W = $clog2(MAX_PENDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state, state_nxt;
   logic              grant, grant_nxt;
   logic              last_grant;
   logic              id_mem [MAX_PENDING];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full, empty;
   logic              el0, el1;
   logic              g_read, g_write;
   logic              accept, push, pop;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A read+write pair from one master is treated as a read, so read_i decides
   // which eligibility rule applies.
   assign el0 = m0_read_i ? !full : m0_write_i;
   assign el1 = m1_read_i ? !full : m1_write_i;

   assign g_read  = grant ? m1_read_i  : m0_read_i;
   assign g_write = grant ? m1_write_i : m0_write_i;

   // Response steering: the FIFO head names the master owning this beat.
   assign pop                = s_readdatavalid_i & !empty;
   assign m0_readdatavalid_o = pop & !id_mem[rd_ptr];
   assign m1_readdatavalid_o = pop &  id_mem[rd_ptr];
   assign m0_readdata_o      = s_readdata_i;
   assign m1_readdata_o      = s_readdata_i;

   // Arbitration / slave-port muxing and next-state logic.
   always_comb begin
      state_nxt        = state;
      grant_nxt        = grant;
      s_address_o      = grant ? m1_address_i   : m0_address_i;
      s_writedata_o    = grant ? m1_writedata_i : m0_writedata_i;
      s_read_o         = 1'b0;
      s_write_o        = 1'b0;
      m0_waitrequest_o = 1'b1;
      m1_waitrequest_o = 1'b1;
      accept           = 1'b0;
      push             = 1'b0;
      case (state)
         IDLE: begin
            if (el0 || el1) begin
               state_nxt = BUSY;
               grant_nxt = (el0 && el1) ? !last_grant : el1;
            end
         end
         BUSY: begin
            // The full gate only matters if the granted master switched from a
            // write to a read while the FIFO filled; it prevents an overflow.
            s_read_o  = g_read & !full;
            s_write_o = g_write & !g_read;
            if (grant) m1_waitrequest_o = s_waitrequest_i;
            else       m0_waitrequest_o = s_waitrequest_i;
            accept = (s_read_o | s_write_o) & !s_waitrequest_i;
            push   = accept & s_read_o;
            if (accept || !(g_read || g_write)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state: FSM, grant history, FIFO pointers/count and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_o      <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         if (accept) last_grant <= grant;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (s_readdatavalid_i && empty) err_o <= 1'b1;
      end
   end

   // ID storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk_i) begin
      if (push) id_mem[wr_ptr] <= grant;
   end

endmodule

// File: tb/tb_sram_amm_arbiter.sv
// Directed bench for sram_amm_arbiter with a behavioural SRAM controller model
// (programmable read latency, forced waitrequest and forced readdatavalid).
module tb_sram_amm_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [17:0] m0_address_i, m1_address_i;
   logic        m0_read_i, m0_write_i, m1_read_i, m1_write_i;
   logic [15:0] m0_writedata_i, m1_writedata_i;
   logic        m0_waitrequest_o, m1_waitrequest_o;
   logic        m0_readdatavalid_o, m1_readdatavalid_o;
   logic [15:0] m0_readdata_o, m1_readdata_o;
   logic [17:0] s_address_o;
   logic        s_read_o, s_write_o;
   logic [15:0] s_writedata_o;
   logic        s_waitrequest_i, s_readdatavalid_i;
   logic [15:0] s_readdata_i;
   logic        err_o;

   logic        sw;
   logic        force_rdv;
   logic        mdl_rdv;
   logic [15:0] mdl_rdata;
   int          lat;
   int          cyc;
   int          compared;
   int          mismatched;

   typedef struct { logic [15:0] d; int due; } rsp_t;
   typedef struct { int m; logic [15:0] d; } exp_t;
   typedef struct { bit rd; logic [17:0] a; logic [15:0] d; } op_t;

   rsp_t        rq[$];
   exp_t        exq[$];
   logic [15:0] mem   [0:4095];
   bit          wrote [0:4095];

   assign s_waitrequest_i   = sw;
   assign s_readdatavalid_i = mdl_rdv | force_rdv;
   assign s_readdata_i      = mdl_rdata;

   sram_amm_arbiter #(.ADDR_W(18), .DATA_W(16), .MAX_PENDING(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_address_i(m0_address_i), .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
      .m0_writedata_i(m0_writedata_i), .m0_waitrequest_o(m0_waitrequest_o),
      .m0_readdatavalid_o(m0_readdatavalid_o), .m0_readdata_o(m0_readdata_o),
      .m1_address_i(m1_address_i), .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
      .m1_writedata_i(m1_writedata_i), .m1_waitrequest_o(m1_waitrequest_o),
      .m1_readdatavalid_o(m1_readdatavalid_o), .m1_readdata_o(m1_readdata_o),
      .s_address_o(s_address_o), .s_read_o(s_read_o), .s_write_o(s_write_o),
      .s_writedata_o(s_writedata_o), .s_waitrequest_i(s_waitrequest_i),
      .s_readdatavalid_i(s_readdatavalid_i), .s_readdata_i(s_readdata_i),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   // Cycle counter: equals the current cycle index between posedges.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] rd_val(input logic [17:0] a);
      if (wrote[a[11:0]]) return mem[a[11:0]];
      case (a)
         18'h00100: return 16'h1111;
         18'h00200: return 16'h2222;
         18'h00300: return 16'h3333;
         18'h00400: return 16'hB000;
         18'h00401: return 16'hB001;
         18'h00402: return 16'hB002;
         18'h00500: return 16'hC000;
         18'h00501: return 16'hC001;
         default:   return 16'h0000;
      endcase
   endfunction

   // Controller model: acts on negedges, where the arbiter's requests are stable.
   always @(negedge clk) begin
      if (rst_i) begin
         rq.delete();
         mdl_rdv   <= 1'b0;
         mdl_rdata <= 16'h0000;
      end else begin
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            mdl_rdv   <= 1'b1;
            mdl_rdata <= rq[0].d;
            rq.pop_front();
         end else begin
            mdl_rdv   <= 1'b0;
            mdl_rdata <= 16'h0000;
         end
         if (s_write_o && !s_waitrequest_i) begin
            mem[s_address_o[11:0]]   <= s_writedata_o;
            wrote[s_address_o[11:0]] <= 1'b1;
         end
         if (s_read_o && !s_waitrequest_i)
            rq.push_back('{d: rd_val(s_address_o), due: cyc + lat});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tmo(input string tag);
      compared++;
      mismatched++;
      $error("FAIL %s: timed out waiting for DUT", tag);
   endtask

   task automatic check_rdv();
      exp_t e;
      if (m0_readdatavalid_o || m1_readdatavalid_o) begin
         chk("rdv_onehot", {31'd0, m0_readdatavalid_o & m1_readdatavalid_o}, 0);
         chk("rdata_bus", {16'd0, m0_readdata_o}, {16'd0, s_readdata_i});
         if (exq.size() == 0) begin
            tmo("rdv_unexpected");
         end else begin
            e = exq.pop_front();
            chk("rdv_master", {31'd0, m1_readdatavalid_o}, e.m);
            chk("rdv_data", {16'd0, m1_readdatavalid_o ? m1_readdata_o : m0_readdata_o},
                {16'd0, e.d});
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #2;
      check_rdv();
   endtask

   task automatic set_req(input int m, input bit rd, input bit wr,
                          input logic [17:0] a, input logic [15:0] d);
      if (m == 0) begin
         m0_read_i = rd; m0_write_i = wr; m0_address_i = a; m0_writedata_i = d;
      end else begin
         m1_read_i = rd; m1_write_i = wr; m1_address_i = a; m1_writedata_i = d;
      end
   endtask

   task automatic do_xfer(input int m, input bit rd, input logic [17:0] a,
                          input logic [15:0] d);
      bit done = 1'b0;
      set_req(m, rd, !rd, a, d);
      for (int i = 0; i < 20 && !done; i++) begin
         sample();
         if ((m == 0 && !m0_waitrequest_o) || (m == 1 && !m1_waitrequest_o)) begin
            done = 1'b1;
            if (rd) exq.push_back('{m: m, d: d});
         end
         tick();
      end
      set_req(m, 1'b0, 1'b0, a, d);
      if (!done) tmo("xfer");
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && exq.size() > 0; i++) begin
         sample();
         tick();
      end
      if (exq.size() > 0) tmo("drain");
   endtask

   op_t ops0 [3];
   op_t ops1 [4];

   initial begin
      int acc, prev, n0, n1, i0, i1, g;
      bit a0, a1;
      rst_i = 1'b1; sw = 1'b0; force_rdv = 1'b0; lat = 1;
      set_req(0, 0, 0, 18'h0, 16'h0);
      set_req(1, 0, 0, 18'h0, 16'h0);
      repeat (3) tick();
      rst_i = 1'b0;

      // Reset state
      sample();
      chk("rst_m0_wait", {31'd0, m0_waitrequest_o}, 1);
      chk("rst_m1_wait", {31'd0, m1_waitrequest_o}, 1);
      chk("rst_m0_rdv", {31'd0, m0_readdatavalid_o}, 0);
      chk("rst_m1_rdv", {31'd0, m1_readdatavalid_o}, 0);
      chk("rst_s_rw", {30'd0, s_read_o, s_write_o}, 0);
      chk("rst_err", {31'd0, err_o}, 0);

      // Single write then read-back from m0
      tick();
      set_req(0, 0, 1, 18'h00010, 16'hA5A5);
      sample();
      chk("t1_arb_cycle_swrite", {31'd0, s_write_o}, 0);
      chk("t1_arb_cycle_wait", {31'd0, m0_waitrequest_o}, 1);
      tick();
      sample();
      chk("t1_swrite", {31'd0, s_write_o}, 1);
      chk("t1_sread", {31'd0, s_read_o}, 0);
      chk("t1_saddr", {14'd0, s_address_o}, 32'h10);
      chk("t1_swdata", {16'd0, s_writedata_o}, 32'hA5A5);
      chk("t1_m0_wait", {31'd0, m0_waitrequest_o}, 0);
      chk("t1_m1_wait", {31'd0, m1_waitrequest_o}, 1);
      tick();
      set_req(0, 0, 0, 18'h00010, 16'hA5A5);
      do_xfer(0, 1'b1, 18'h00010, 16'hA5A5);
      drain(20);

      // Continuous write contention from reset: strict alternation m0,m1,...
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      n0 = 0; n1 = 0; acc = 0; prev = -1;
      set_req(0, 0, 1, 18'h00020, 16'h0000);
      set_req(1, 0, 1, 18'h00040, 16'h8000);
      for (int c = 0; c < 40 && acc < 8; c++) begin
         sample();
         if (!m0_waitrequest_o || !m1_waitrequest_o) begin
            g = !m1_waitrequest_o ? 1 : 0;
            chk("rr_single_grant", {30'd0, m0_waitrequest_o, m1_waitrequest_o} != 0, 1);
            chk("rr_grant", g, acc % 2);
            chk("rr_wdata", {16'd0, s_writedata_o}, g ? 32'h8000 + n1 : 32'h0000 + n0);
            chk("rr_addr", {14'd0, s_address_o}, g ? 32'h40 + n1 : 32'h20 + n0);
            if (prev >= 0) chk("rr_spacing", cyc - prev, 2);
            prev = cyc;
            acc++;
            tick();
            if (g == 0) begin n0++; set_req(0, 0, 1, 18'(32'h20 + n0), 16'(n0)); end
            else begin n1++; set_req(1, 0, 1, 18'(32'h40 + n1), 16'(32'h8000 + n1)); end
         end else begin
            tick();
         end
      end
      if (acc < 8) tmo("rr_accepts");
      set_req(0, 0, 0, 18'h0, 16'h0);
      set_req(1, 0, 0, 18'h0, 16'h0);

      // Interleaved reads from both masters with latency
      lat = 6;
      do_xfer(0, 1'b1, 18'h00100, 16'h1111);
      do_xfer(1, 1'b1, 18'h00200, 16'h2222);
      do_xfer(0, 1'b1, 18'h00300, 16'h3333);
      drain(40);

      // Long latency: FIFO fills, a write still passes, all reads complete
      lat = 12;
      ops0[0] = '{1'b1, 18'h00400, 16'hB000};
      ops0[1] = '{1'b1, 18'h00401, 16'hB001};
      ops0[2] = '{1'b1, 18'h00402, 16'hB002};
      ops1[0] = '{1'b1, 18'h00500, 16'hC000};
      ops1[1] = '{1'b1, 18'h00501, 16'hC001};
      ops1[2] = '{1'b0, 18'h00600, 16'hD00D};
      ops1[3] = '{1'b1, 18'h00600, 16'hD00D};
      i0 = 0; i1 = 0;
      for (int c = 0; c < 200 && !(i0 == 3 && i1 == 4 && exq.size() == 0); c++) begin
         if (i0 < 3) set_req(0, ops0[i0].rd, !ops0[i0].rd, ops0[i0].a, ops0[i0].d);
         else        set_req(0, 0, 0, 18'h0, 16'h0);
         if (i1 < 4) set_req(1, ops1[i1].rd, !ops1[i1].rd, ops1[i1].a, ops1[i1].d);
         else        set_req(1, 0, 0, 18'h0, 16'h0);
         sample();
         if (exq.size() == 4) chk("no_read_when_full", {31'd0, s_read_o}, 0);
         a0 = (i0 < 3) && !m0_waitrequest_o;
         a1 = (i1 < 4) && !m1_waitrequest_o;
         if (a0) begin
            exq.push_back('{m: 0, d: ops0[i0].d});
            i0++;
         end
         if (a1) begin
            if (ops1[i1].rd) exq.push_back('{m: 1, d: ops1[i1].d});
            else chk("wr_passes_full", exq.size(), 4);
            i1++;
         end
         if (a0 || a1) chk("outstanding_le_max", {31'd0, exq.size() <= 4}, 1);
         tick();
      end
      if (!(i0 == 3 && i1 == 4 && exq.size() == 0)) tmo("long_latency");
      set_req(0, 0, 0, 18'h0, 16'h0);
      set_req(1, 0, 0, 18'h0, 16'h0);

      // Underflow: forced readdatavalid with nothing pending
      tick();
      force_rdv = 1'b1;
      sample();
      chk("uf_m0_rdv", {31'd0, m0_readdatavalid_o}, 0);
      chk("uf_m1_rdv", {31'd0, m1_readdatavalid_o}, 0);
      chk("uf_err_before_edge", {31'd0, err_o}, 0);
      tick();
      force_rdv = 1'b0;
      sample();
      chk("uf_err_set", {31'd0, err_o}, 1);
      repeat (3) tick();
      sample();
      chk("uf_err_sticky", {31'd0, err_o}, 1);

      // Reset while m1 is granted and stalled, with one read outstanding
      tick();
      lat = 20;
      do_xfer(0, 1'b1, 18'h00010, 16'hA5A5);
      sw = 1'b1;
      set_req(1, 1, 0, 18'h00200, 16'h0);
      sample();
      chk("mr_idle_m1_wait", {31'd0, m1_waitrequest_o}, 1);
      tick();
      sample();
      chk("mr_busy_sread", {31'd0, s_read_o}, 1);
      chk("mr_busy_saddr", {14'd0, s_address_o}, 32'h200);
      chk("mr_busy_m1_wait", {31'd0, m1_waitrequest_o}, 1);
      chk("mr_busy_m0_wait", {31'd0, m0_waitrequest_o}, 1);
      tick();
      rst_i = 1'b1;
      sample();
      tick();
      rst_i = 1'b0; sw = 1'b0;
      set_req(1, 0, 0, 18'h0, 16'h0);
      exq.delete();
      sample();
      chk("mr_post_m0_wait", {31'd0, m0_waitrequest_o}, 1);
      chk("mr_post_m1_wait", {31'd0, m1_waitrequest_o}, 1);
      chk("mr_post_s_rw", {30'd0, s_read_o, s_write_o}, 0);
      chk("mr_post_err", {31'd0, err_o}, 0);
      tick();
      set_req(0, 0, 1, 18'h00030, 16'h1234);
      set_req(1, 0, 1, 18'h00031, 16'h5678);
      sample();
      chk("tie_idle_waits", {30'd0, m0_waitrequest_o, m1_waitrequest_o}, 3);
      tick();
      sample();
      chk("tie_m0_wait", {31'd0, m0_waitrequest_o}, 0);
      chk("tie_m1_wait", {31'd0, m1_waitrequest_o}, 1);
      chk("tie_wdata", {16'd0, s_writedata_o}, 32'h1234);
      tick();
      set_req(0, 0, 0, 18'h0, 16'h0);
      set_req(1, 0, 0, 18'h0, 16'h0);
      tick();
      force_rdv = 1'b1;
      sample();
      chk("mr_fifo_empty_m0", {31'd0, m0_readdatavalid_o}, 0);
      chk("mr_fifo_empty_m1", {31'd0, m1_readdatavalid_o}, 0);
      tick();
      force_rdv = 1'b0;
      sample();
      chk("mr_fifo_empty_err", {31'd0, err_o}, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
